intr_vec_sink: RTL

Receiving end of the interrupt-vector link driven by the interrupt serializer. Watches the `intr_vec_req`/`intr_num` pulse stream and validates each pulse against the link rules (one-hot, stable, minimum width). It records accepted vectors as per-port pending bits and hands them one at a time to the consumer over a valid/ready port, lowest index first. It also flags protocol errors and per-port overruns.

---
 rtl/intr_pkg.sv | 30 +++
 rtl/priority_encoder.sv | 37 +++
 rtl/intr_vec_sink.sv | 169 ++++++++++++++++
 3 files changed

// File: rtl/intr_pkg.sv
// Shared definitions for the interrupt-vector link receiver.
// Contents:
//   link_state_e  - link FSM state encoding (STATE_BITS wide)
//   ERR_CNT_W     - width of the rejected-pulse counter
//   ERR_CNT_MAX   - saturation value of that counter
//   sat_inc8      - saturating increment used by the counters
package intr_pkg;

    localparam int STATE_BITS = 2;

    typedef enum logic [STATE_BITS-1:0] {
        S_IDLE = 2'd0,
        S_HIGH = 2'd1
    } link_state_e;

    localparam int                   ERR_CNT_W   = 8;
    localparam logic [ERR_CNT_W-1:0] ERR_CNT_MAX = 8'd255;

    // Increment that sticks at ERR_CNT_MAX instead of wrapping.
    function automatic logic [ERR_CNT_W-1:0] sat_inc8(input logic [ERR_CNT_W-1:0] v);
        logic [ERR_CNT_W-1:0] r;
        if (v == ERR_CNT_MAX) begin
            r = v;
        end else begin
            r = v + 8'd1;
        end
        return r;
    endfunction

endpackage

// File: rtl/priority_encoder.sv
// Priority encoder: returns the binary index of the highest-priority set bit.
// Ports:
//   req_i   - request vector
//   idx_o   - index of the winning bit (0 when no bit is set)
//   valid_o - at least one bit of req_i is set
// LSB_HIGH_PRIORITY=1 gives bit 0 the highest priority.
module priority_encoder #(
    parameter int WIDTH             = 4,
    parameter bit LSB_HIGH_PRIORITY = 1'b1,
    localparam int IDX_W            = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
    input  logic [WIDTH-1:0] req_i,
    output logic [IDX_W-1:0] idx_o,
    output logic             valid_o
);

    assign valid_o = |req_i;

    if (LSB_HIGH_PRIORITY) begin : g_lsb
        // Scan from the top down so the lowest set bit is written last.
        always_comb begin
            idx_o = '0;
            for (int i = WIDTH - 1; i >= 0; i--) begin
                idx_o = req_i[i] ? IDX_W'(i) : idx_o;
            end
        end
    end else begin : g_msb
        // Scan from the bottom up so the highest set bit is written last.
        always_comb begin
            idx_o = '0;
            for (int i = 0; i < WIDTH; i++) begin
                idx_o = req_i[i] ? IDX_W'(i) : idx_o;
            end
        end
    end

endmodule

// File: rtl/intr_vec_sink.sv
// Receiving end of the interrupt-vector link.
// Validates each intr_vec_req pulse (one-hot, in range, stable, long enough),
// records accepted vectors as per-port pending bits and presents them one at
// a time, lowest index first, over a valid/ready port.
// Ports:
//   clk, rst       - clock, synchronous active-high reset
//   intr_vec_req   - pulse from the serializer
//   intr_num       - one-hot vector number, valid while intr_vec_req is high
//   vec_valid/vec_ready/vec_index - consumer handshake and binary port index
//   overrun        - sticky per-port "event while already pending" flags
//   err_pulse      - one-cycle strobe on a rejected pulse
//   err_count      - saturating count of rejected pulses
//   clear_status   - clears overrun and err_count
module intr_vec_sink
    import intr_pkg::*;
#(
    parameter int PORTS      = 4,
    parameter int MIN_CYCLES = 2,
    localparam int IDX_W     = (PORTS > 1) ? $clog2(PORTS) : 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 intr_vec_req,
    input  logic [31:0]          intr_num,
    output logic                 vec_valid,
    input  logic                 vec_ready,
    output logic [IDX_W-1:0]     vec_index,
    output logic [PORTS-1:0]     overrun,
    output logic                 err_pulse,
    output logic [ERR_CNT_W-1:0] err_count,
    input  logic                 clear_status
);

    localparam logic [31:0]      PORT_MASK = (PORTS >= 32) ? 32'hFFFF_FFFF
                                                           : ((32'd1 << PORTS) - 32'd1);
    localparam logic [PORTS-1:0] ONE_P     = PORTS'(1'b1);

    link_state_e          state_q;
    logic [31:0]          num_q;
    logic [7:0]           cnt_q;
    logic                 unstable_q;
    logic                 req_prev_q;

    logic [PORTS-1:0]     pending_q, pending_d;
    logic [PORTS-1:0]     overrun_q, overrun_d;
    logic                 vec_valid_q, vec_valid_d;
    logic [IDX_W-1:0]     vec_index_q, vec_index_d;
    logic                 err_pulse_q;
    logic [ERR_CNT_W-1:0] err_count_q, err_count_d;

    logic [IDX_W-1:0]     pend_idx_s, num_idx_s;
    logic                 pend_hit_s, num_hit_s;
    logic                 pulse_end_s, legal_s, accept_s, reject_s, load_s;
    logic [PORTS-1:0]     set_mask_s, take_mask_s;

    priority_encoder #(.WIDTH(PORTS), .LSB_HIGH_PRIORITY(1'b1)) u_pend_enc (
        .req_i   (pending_q),
        .idx_o   (pend_idx_s),
        .valid_o (pend_hit_s)
    );

    priority_encoder #(.WIDTH(PORTS), .LSB_HIGH_PRIORITY(1'b1)) u_num_enc (
        .req_i   (num_q[PORTS-1:0]),
        .idx_o   (num_idx_s),
        .valid_o (num_hit_s)
    );

    // A pulse ends on the first low sample while in S_HIGH; judge it then.
    // num_hit_s together with the range check is equivalent to num_q != 0.
    assign pulse_end_s = (state_q == S_HIGH) && !intr_vec_req;
    assign legal_s     = num_hit_s
                      && ((num_q & (num_q - 32'd1)) == 32'd0)
                      && ((num_q & ~PORT_MASK) == 32'd0)
                      && (cnt_q >= 8'(MIN_CYCLES))
                      && !unstable_q;
    assign accept_s    = pulse_end_s && legal_s;
    assign reject_s    = pulse_end_s && !legal_s;
    assign load_s      = !vec_valid_q || vec_ready;

    // Link FSM; req_prev_q is sampled during reset so a pulse already high at release is ignored.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            num_q      <= 32'd0;
            cnt_q      <= 8'd0;
            unstable_q <= 1'b0;
            req_prev_q <= intr_vec_req;
        end else begin
            req_prev_q <= intr_vec_req;
            case (state_q)
                S_IDLE: begin
                    if (intr_vec_req && !req_prev_q) begin
                        num_q      <= intr_num;
                        cnt_q      <= 8'd1;
                        unstable_q <= 1'b0;
                        state_q    <= S_HIGH;
                    end else begin
                        state_q    <= S_IDLE;
                    end
                end
                S_HIGH: begin
                    if (intr_vec_req) begin
                        cnt_q <= sat_inc8(cnt_q);
                        if (intr_num != num_q) begin
                            unstable_q <= 1'b1;
                        end else begin
                            unstable_q <= unstable_q;
                        end
                    end else begin
                        state_q <= S_IDLE;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    // Next-state for pending bits, output register and status.
    // A set and a take of the same bit leave it set and do not count as overrun.
    always_comb begin
        set_mask_s  = accept_s ? (ONE_P << num_idx_s) : '0;
        take_mask_s = (load_s && pend_hit_s) ? (ONE_P << pend_idx_s) : '0;
        pending_d   = (pending_q & ~take_mask_s) | set_mask_s;
        overrun_d   = (clear_status ? '0 : overrun_q)
                    | (set_mask_s & pending_q & ~take_mask_s);

        if (reject_s) begin
            err_count_d = clear_status ? 8'd1 : sat_inc8(err_count_q);
        end else begin
            err_count_d = clear_status ? 8'd0 : err_count_q;
        end

        if (load_s) begin
            vec_valid_d = pend_hit_s;
            vec_index_d = pend_hit_s ? pend_idx_s : vec_index_q;
        end else begin
            vec_valid_d = vec_valid_q;
            vec_index_d = vec_index_q;
        end
    end

    // Pending, output and status registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            pending_q   <= '0;
            overrun_q   <= '0;
            vec_valid_q <= 1'b0;
            vec_index_q <= '0;
            err_pulse_q <= 1'b0;
            err_count_q <= 8'd0;
        end else begin
            pending_q   <= pending_d;
            overrun_q   <= overrun_d;
            vec_valid_q <= vec_valid_d;
            vec_index_q <= vec_index_d;
            err_pulse_q <= reject_s;
            err_count_q <= err_count_d;
        end
    end

    assign vec_valid = vec_valid_q;
    assign vec_index = vec_index_q;
    assign overrun   = overrun_q;
    assign err_pulse = err_pulse_q;
    assign err_count = err_count_q;

endmodule
